// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared states, CSR offsets and bit positions for the copy engine
package dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RGAP,
      S_WR,
      S_WGAP
   } dma_state_t;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_SRC    = 8'h08;
   localparam logic [7:0] OFF_DST    = 8'h0C;
   localparam logic [7:0] OFF_LEN    = 8'h10;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_ABORT  = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;

endpackage

// File: rtl/dma_csr.sv
// rtl/dma_csr.sv - CSR slave: decode, single-cycle ack, control/status registers
module dma_csr
   import dma_pkg::*;
#(
   parameter logic [31:0] CSR_BASE = 32'h3000_8000,
   parameter int          LEN_W    = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic             busy,
   input  logic             set_done,
   input  logic             set_aborted,
   output logic             start,
   output logic             abort,
   output logic [31:0]      src,
   output logic [31:0]      dst,
   output logic [LEN_W-1:0] len,
   output logic             irq_en,
   output logic             irq_o
);

   logic        hit;
   logic        access;
   logic        wr_en;
   logic [7:0]  off;
   logic [31:0] rdata;
   logic        done;
   logic        aborted;

   assign hit    = (wbs_adr_i[31:8] == CSR_BASE[31:8]);
   assign off    = wbs_adr_i[7:0];
   assign access = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
   assign wr_en  = access & wbs_we_i & hit;
   assign irq_o  = done & irq_en;

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (off)
            OFF_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
            OFF_STATUS: begin
               rdata[STAT_BUSY]    = busy;
               rdata[STAT_DONE]    = done;
               rdata[STAT_ABORTED] = aborted;
            end
            OFF_SRC:    rdata = src;
            OFF_DST:    rdata = dst;
            OFF_LEN:    rdata[LEN_W-1:0] = len;
            default:    rdata = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         start     <= 1'b0;
         abort     <= 1'b0;
         src       <= '0;
         dst       <= '0;
         len       <= '0;
         irq_en    <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         wbs_ack_o <= access;
         wbs_dat_o <= access ? rdata : '0;
         // Pulses are qualified by busy here so the FSM never sees a stale request.
         start <= wr_en && (off == OFF_CTRL) && wbs_dat_i[CTRL_START] && !busy;
         abort <= wr_en && (off == OFF_CTRL) && wbs_dat_i[CTRL_ABORT] && busy;
         if (wr_en) begin
            case (off)
               OFF_CTRL: begin
                  irq_en <= wbs_dat_i[CTRL_IRQ_EN];
                  if (wbs_dat_i[CTRL_START] && !busy) begin
                     done    <= 1'b0;
                     aborted <= 1'b0;
                  end
               end
               OFF_STATUS: begin
                  if (wbs_dat_i[STAT_DONE])    done    <= 1'b0;
                  if (wbs_dat_i[STAT_ABORTED]) aborted <= 1'b0;
               end
               OFF_SRC: if (!busy) src <= {wbs_dat_i[31:2], 2'b00};
               OFF_DST: if (!busy) dst <= {wbs_dat_i[31:2], 2'b00};
               OFF_LEN: if (!busy) len <= wbs_dat_i[LEN_W-1:0];
               default: ;
            endcase
         end
         if (set_done)    done    <= 1'b1;
         if (set_aborted) aborted <= 1'b1;
      end
   end

endmodule

// File: rtl/wb_dma_copy.sv
// rtl/wb_dma_copy.sv - word copy engine: read/write FSM with a gap cycle after every beat
module wb_dma_copy
   import dma_pkg::*;
#(
   parameter logic [31:0] CSR_BASE = 32'h3000_8000,
   parameter int          LEN_W    = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic        irq_o
);

   dma_state_t       state;
   logic             start;
   logic             abort;
   logic [31:0]      src;
   logic [31:0]      dst;
   logic [LEN_W-1:0] len;
   logic             irq_en;
   logic             busy;
   logic             set_done;
   logic             set_aborted;
   logic             stop_req;
   logic             stopping;
   logic [31:0]      rd_adr;
   logic [31:0]      wr_adr;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      data_buf;
   logic             sel_unused;

   assign sel_unused = ^wbs_sel_i;
   assign busy       = (state != S_IDLE);
   assign stopping   = stop_req | abort;

   dma_csr #(.CSR_BASE(CSR_BASE), .LEN_W(LEN_W)) u_csr (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .busy        (busy),
      .set_done    (set_done),
      .set_aborted (set_aborted),
      .start       (start),
      .abort       (abort),
      .src         (src),
      .dst         (dst),
      .len         (len),
      .irq_en      (irq_en),
      .irq_o       (irq_o)
   );

   // Completion is only judged in the gap cycles, after any in-flight beat has been acked.
   always_comb begin
      set_done    = 1'b0;
      set_aborted = 1'b0;
      if (state == S_IDLE && start && len == '0)
         set_done = 1'b1;
      if ((state == S_RGAP || state == S_WGAP) && stopping)
         set_aborted = 1'b1;
      else if (state == S_WGAP && remaining == '0)
         set_done = 1'b1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= S_IDLE;
         stop_req  <= 1'b0;
         rd_adr    <= '0;
         wr_adr    <= '0;
         remaining <= '0;
         data_buf  <= '0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'h0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else begin
         wbm_sel_o <= 4'hF;
         if (abort && busy) stop_req <= 1'b1;
         case (state)
            S_IDLE: begin
               stop_req <= 1'b0;
               if (start) begin
                  rd_adr    <= src;
                  wr_adr    <= dst;
                  remaining <= len;
                  if (len != '0) begin
                     wbm_cyc_o <= 1'b1;
                     wbm_stb_o <= 1'b1;
                     wbm_we_o  <= 1'b0;
                     wbm_adr_o <= src;
                     state     <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (wbm_ack_i) begin
                  data_buf  <= wbm_dat_i;
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  state     <= S_RGAP;
               end
            end
            S_RGAP: begin
               if (stopping) begin
                  state <= S_IDLE;
               end else begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b1;
                  wbm_adr_o <= wr_adr;
                  wbm_dat_o <= data_buf;
                  state     <= S_WR;
               end
            end
            S_WR: begin
               if (wbm_ack_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  rd_adr    <= rd_adr + 32'd4;
                  wr_adr    <= wr_adr + 32'd4;
                  remaining <= remaining - LEN_W'(1);
                  state     <= S_WGAP;
               end
            end
            S_WGAP: begin
               if (stopping || remaining == '0) begin
                  state <= S_IDLE;
               end else begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b0;
                  wbm_adr_o <= rd_adr;
                  state     <= S_RD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb/tb_wb_dma_copy.sv - directed bench with RAM model and access scoreboard for wb_dma_copy
module tb_wb_dma_copy;

   localparam logic [31:0] BASE = 32'h3000_8000;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [31:0] adr, wdat;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        wbm_stb_o, wbm_cyc_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        ram_ack;
   logic [31:0] ram_rdata;
   logic        irq_o;

   logic [31:0] mem [0:1023];
   int          lat_cnt;
   int          lat;
   logic        hammer;
   acc_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          mcyc_cnt = 0;
   logic        prev_rst = 1'b1;
   logic        prev_stb = 1'b0;
   logic        prev_ack = 1'b0;

   always #5 clk = ~clk;

   wb_dma_copy dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (4'hF),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_i (ram_ack),
      .wbm_dat_i (ram_rdata),
      .irq_o     (irq_o)
   );

   function automatic logic [31:0] init_word(input int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   // RAM behind the arbiter: fixed ack latency, optional CPU traffic elsewhere in RAM
   assign ram_ack   = wbm_cyc_o & wbm_stb_o & (lat_cnt == lat);
   assign ram_rdata = mem[wbm_adr_o[11:2]];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
         lat_cnt <= 0;
      end else begin
         if (wbm_cyc_o && wbm_stb_o && !ram_ack) lat_cnt <= lat_cnt + 1;
         else lat_cnt <= 0;
         if (ram_ack && wbm_we_o) mem[wbm_adr_o[11:2]] <= wbm_dat_o;
         if (hammer) mem[512 + $urandom_range(0, 255)] <= $urandom;
      end
   end

   // Compare process: protocol rules and every acked access against the expected list
   always @(negedge clk) begin
      if (rst || prev_rst) begin
         prev_stb <= 1'b0;
         prev_ack <= 1'b0;
      end else begin
         total++;
         if (wbm_sel_o !== 4'hF) begin
            bad++;
            $display("FAIL sel: got %h want f", wbm_sel_o);
         end
         if (prev_stb && !prev_ack) begin
            total++;
            if (wbm_stb_o !== 1'b1) begin
               bad++;
               $display("FAIL stb_hold: stb dropped before ack, got %b want 1", wbm_stb_o);
            end
         end
         if (prev_ack) begin
            total++;
            if (wbm_cyc_o !== 1'b0) begin
               bad++;
               $display("FAIL gap: cyc after ack got %b want 0", wbm_cyc_o);
            end
         end
         if (wbm_cyc_o) mcyc_cnt <= mcyc_cnt + 1;
         if (wbm_cyc_o && wbm_stb_o && ram_ack) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL access: unexpected we=%b adr=%h, want none", wbm_we_o, wbm_adr_o);
            end else begin
               acc_t e;
               e = exp_q.pop_front();
               if (wbm_we_o !== e.we || wbm_adr_o !== e.adr || (e.we && wbm_dat_o !== e.dat)) begin
                  bad++;
                  $display("FAIL access: got we=%b adr=%h dat=%h want we=%b adr=%h dat=%h",
                           wbm_we_o, wbm_adr_o, wbm_dat_o, e.we, e.adr, e.dat);
               end
            end
         end
         prev_stb <= wbm_stb_o;
         prev_ack <= ram_ack;
      end
      prev_rst <= rst;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic csr_xfer(input logic wr, input logic [7:0] off, input logic [31:0] d,
                           output logic [31:0] rd);
      int k;
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = wr; adr = BASE + {24'h0, off}; wdat = d;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!wbs_ack_o && k < 8);
      if (!wbs_ack_o) chk("csr_ack_timeout", {31'h0, wbs_ack_o}, 32'h1);
      rd = wbs_dat_o;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic csr_wr(input logic [7:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      csr_xfer(1'b1, off, d, dummy);
   endtask

   task automatic csr_rd(input logic [7:0] off, output logic [31:0] d);
      csr_xfer(1'b0, off, 32'h0, d);
   endtask

   task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{1'b0, s + 32'(4 * i), 32'h0});
         exp_q.push_back('{1'b1, d + 32'(4 * i), init_word(int'(s[11:2]) + i)});
      end
   endtask

   task automatic wait_irq(output int k, input int limit);
      k = 0;
      while (!irq_o && k < limit) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic check_dst(input string name, input int s_idx, input int d_idx, input int n);
      for (int i = 0; i < n; i++) chk(name, mem[d_idx + i], init_word(s_idx + i));
   endtask

   initial begin
      logic [31:0] r;
      int k;
      int mc;
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; wdat = '0;
      lat = 0; hammer = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", {28'h0, wbm_sel_o}, 32'h0);
      chk("rst_master", {29'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'h0);
      chk("rst_adr", wbm_adr_o, 32'h0);
      chk("rst_slave", {31'h0, wbs_ack_o} | wbs_dat_o, 32'h0);
      chk("rst_irq", {31'h0, irq_o}, 32'h0);
      rst = 1'b0;

      // Copy with same-cycle ack
      csr_wr(8'h08, 32'h3800_0003);
      csr_rd(8'h08, r);
      chk("src_low_bits", r, 32'h3800_0000);
      csr_wr(8'h0C, 32'h3800_0100);
      csr_wr(8'h10, 32'd4);
      csr_rd(8'h20, r);
      chk("unmapped_read", r, 32'h0);
      expect_copy(32'h3800_0000, 32'h3800_0100, 4);
      csr_wr(8'h00, 32'h3);
      @(posedge clk); #1;
      chk("copy_rd_entry", {30'h0, wbm_cyc_o, wbm_we_o}, 32'h2);
      wait_irq(k, 200);
      chk("copy_done_cycles", k, 16);
      chk("pin_dst0", mem[64], 32'h5A00_0000);
      chk("pin_dst3", mem[67], 32'h5A03_0303);
      check_dst("copy_dst", 0, 64, 4);
      chk("copy_q_empty", exp_q.size(), 0);
      csr_rd(8'h04, r);
      chk("copy_status", r, 32'h2);

      // Contention: 2-cycle ack latency while other RAM words change
      lat = 2; hammer = 1'b1;
      csr_wr(8'h08, 32'h3800_0200);
      csr_wr(8'h0C, 32'h3800_0300);
      csr_wr(8'h10, 32'd8);
      expect_copy(32'h3800_0200, 32'h3800_0300, 8);
      csr_wr(8'h00, 32'h3);
      chk("cont_irq_cleared", {31'h0, irq_o}, 32'h0);
      @(posedge clk); #1;
      wait_irq(k, 400);
      chk("cont_done_cycles", k, 64);
      hammer = 1'b0;
      check_dst("cont_dst", 128, 192, 8);
      chk("cont_q_empty", exp_q.size(), 0);

      // LEN=0: done one cycle after the ack, no master traffic
      csr_wr(8'h10, 32'd0);
      mc = mcyc_cnt;
      csr_wr(8'h00, 32'h3);
      chk("len0_ack_cycle_irq", {31'h0, irq_o}, 32'h0);
      @(posedge clk); #1;
      chk("len0_irq_next", {31'h0, irq_o}, 32'h1);
      chk("len0_no_cyc", {31'h0, wbm_cyc_o}, 32'h0);
      repeat (3) @(posedge clk);
      csr_rd(8'h04, r);
      chk("len0_status", r, 32'h2);
      chk("len0_master_cycles", mcyc_cnt - mc, 0);

      // Abort during the write of word 2 of 5
      lat = 6;
      csr_wr(8'h08, 32'h3800_0400);
      csr_wr(8'h0C, 32'h3800_0500);
      csr_wr(8'h10, 32'd5);
      expect_copy(32'h3800_0400, 32'h3800_0500, 2);
      csr_wr(8'h00, 32'h1);
      k = 0;
      while (!(wbm_cyc_o && wbm_we_o && wbm_adr_o == 32'h3800_0504) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("abort_reached_wr2", {31'h0, wbm_cyc_o & wbm_we_o}, 32'h1);
      csr_wr(8'h00, 32'h4);
      repeat (40) @(posedge clk);
      chk("abort_word1", mem[321], init_word(257));
      chk("abort_word2_untouched", mem[322], init_word(322));
      chk("abort_q_empty", exp_q.size(), 0);
      csr_rd(8'h04, r);
      chk("abort_status", r, 32'h4);
      csr_wr(8'h04, 32'h4);
      csr_rd(8'h04, r);
      chk("abort_status_cleared", r, 32'h0);

      // Interrupt level and SRC write while busy
      lat = 1;
      csr_wr(8'h08, 32'h3800_0600);
      csr_wr(8'h0C, 32'h3800_0700);
      csr_wr(8'h10, 32'd3);
      expect_copy(32'h3800_0600, 32'h3800_0700, 3);
      csr_wr(8'h00, 32'h3);
      csr_wr(8'h08, 32'h3800_0ABC);
      csr_rd(8'h08, r);
      chk("src_locked_busy", r, 32'h3800_0600);
      wait_irq(k, 100);
      chk("irq_set", {31'h0, irq_o}, 32'h1);
      repeat (5) @(posedge clk);
      #1;
      chk("irq_held", {31'h0, irq_o}, 32'h1);
      csr_wr(8'h04, 32'h2);
      chk("irq_cleared", {31'h0, irq_o}, 32'h0);
      check_dst("irq_dst", 384, 448, 3);
      chk("irq_q_empty", exp_q.size(), 0);

      // Reset pulse in the middle of a read
      lat = 3;
      csr_wr(8'h08, 32'h3800_0000);
      csr_wr(8'h0C, 32'h3800_0100);
      csr_wr(8'h10, 32'd2);
      csr_wr(8'h00, 32'h1);
      @(posedge clk); #1;
      chk("mid_rd_active", {31'h0, wbm_cyc_o}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
      rst = 1'b0;
      csr_rd(8'h04, r);
      chk("rst_mid_status", r, 32'h0);
      csr_rd(8'h08, r);
      chk("rst_mid_src", r, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
